// File: rtl/risc_toy_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// risc_toy_mem_arbiter_if
// Bundles the fetch-side request port (I_*), the data-side request port (D_*)
// and the unified memory handshake (M*) used by risc_toy_mem_arbiter.
//   slave  : view taken by the arbiter (requests and MACK/MRDATA in; grants,
//            completions and memory request out).
//   master : view taken by the surrounding pipeline / memory model.
// Parameters: AW word address width, DW data width.
// ---------------------------------------------------------------------------
interface risc_toy_mem_arbiter_if #(
    parameter int AW = 30,
    parameter int DW = 32
);
    // fetch side
    logic          I_REQ;
    logic [AW-1:0] I_ADDR;
    logic          I_GNT;
    logic          I_RVALID;
    logic [DW-1:0] I_RDATA;
    // data side
    logic          D_REQ;
    logic          D_RW;
    logic [AW-1:0] D_ADDR;
    logic [DW-1:0] D_WDATA;
    logic          D_GNT;
    logic          D_RVALID;
    logic [DW-1:0] D_RDATA;
    // memory side
    logic          MREQ;
    logic          MRW;
    logic [AW-1:0] MADDR;
    logic [DW-1:0] MWDATA;
    logic [DW-1:0] MRDATA;
    logic          MACK;

    modport slave (
        input  I_REQ, I_ADDR, D_REQ, D_RW, D_ADDR, D_WDATA, MRDATA, MACK,
        output I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
        output MREQ, MRW, MADDR, MWDATA
    );

    modport master (
        output I_REQ, I_ADDR, D_REQ, D_RW, D_ADDR, D_WDATA, MRDATA, MACK,
        input  I_GNT, I_RVALID, I_RDATA, D_GNT, D_RVALID, D_RDATA,
        input  MREQ, MRW, MADDR, MWDATA
    );
endinterface

// File: rtl/risc_toy_mem_arbiter.sv
// ---------------------------------------------------------------------------
// risc_toy_mem_arbiter
// Shares one single-port memory between the RISC_TOY fetch stage (I side) and
// memory stage (D side). One access is outstanding at a time; the data side
// has priority, but after MAX_DBURST consecutive data grants with a fetch
// waiting the fetch is forced through.
//
// Ports:
//   CLK   rising-edge clock
//   RST   synchronous, active-high reset
//   bus   risc_toy_mem_arbiter_if.slave: I_*/D_* request ports, M* memory port
//   BUSY  an access is outstanding (state != IDLE)
//   ERR   sticky MACK-timeout flag (only with ARB_TIMEOUT_EN, else tied 0)
//
// Option: define ARB_TIMEOUT_EN to abort an access after TIMEOUT MREQ cycles
// without MACK; the requester then sees a completion with 32'hDEAD_BEEF.
// ---------------------------------------------------------------------------
module risc_toy_mem_arbiter #(
    parameter int AW         = 30,
    parameter int DW         = 32,
    parameter int MAX_DBURST = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    risc_toy_mem_arbiter_if.slave   bus,
    output logic                    BUSY,
    output logic                    ERR
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        I_ACC = 2'd1,
        D_ACC = 2'd2
    } state_t;

    state_t     state;
    state_t     state_nxt;
    logic [3:0] dcnt;
    logic       d_win;
    logic       i_win;
    logic       grant_d;
    logic       grant_i;
    logic       done;          // access finishes at this edge
    logic       timeout_hit;
    logic [DW-1:0] rsp_data;

    // D has priority unless a waiting fetch has already seen MAX_DBURST
    // back-to-back data grants.
    assign d_win   = bus.D_REQ && !(bus.I_REQ && (dcnt == 4'(MAX_DBURST)));
    assign i_win   = bus.I_REQ && !d_win;
    assign grant_d = (state == IDLE) && d_win;
    assign grant_i = (state == IDLE) && i_win;

    assign bus.D_GNT = grant_d;
    assign bus.I_GNT = grant_i;
    assign BUSY      = (state != IDLE);
    assign done      = (state != IDLE) && (bus.MACK || timeout_hit);

`ifdef ARB_TIMEOUT_EN
    localparam int            TW         = $clog2(TIMEOUT + 1);
    localparam logic [DW-1:0] ABORT_DATA = DW'(32'hDEAD_BEEF);

    logic [TW-1:0] tcnt;

    // Counts MREQ cycles of the current access; IDLE always clears it.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tcnt <= '0;
        end else if ((state != IDLE) && !bus.MACK) begin
            tcnt <= tcnt + 1'b1;
        end else begin
            tcnt <= '0;
        end
    end

    assign timeout_hit = (state != IDLE) && !bus.MACK && (tcnt == TW'(TIMEOUT - 1));
    assign rsp_data    = bus.MACK ? bus.MRDATA : ABORT_DATA;

    always_ff @(posedge CLK) begin
        if (RST) begin
            ERR <= 1'b0;
        end else if (timeout_hit) begin
            ERR <= 1'b1;
        end
    end
`else
    // Without the abort option the access waits for MACK forever; the
    // comparison below is constant 0 and only keeps TIMEOUT referenced.
    assign timeout_hit = (TIMEOUT < 0);
    assign rsp_data    = bus.MRDATA;
    assign ERR         = 1'b0;
`endif

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (d_win) begin
                    state_nxt = D_ACC;
                end else if (i_win) begin
                    state_nxt = I_ACC;
                end
            end
            I_ACC, D_ACC: begin
                if (bus.MACK || timeout_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Memory request launch and completion return
    always_ff @(posedge CLK) begin
        if (RST) begin
            bus.MREQ     <= 1'b0;
            bus.MRW      <= 1'b0;
            bus.MADDR    <= '0;
            bus.MWDATA   <= '0;
            bus.I_RVALID <= 1'b0;
            bus.I_RDATA  <= '0;
            bus.D_RVALID <= 1'b0;
            bus.D_RDATA  <= '0;
        end else begin
            bus.I_RVALID <= 1'b0;
            bus.D_RVALID <= 1'b0;
            if (grant_d) begin
                bus.MREQ   <= 1'b1;
                bus.MRW    <= bus.D_RW;
                bus.MADDR  <= bus.D_ADDR;
                bus.MWDATA <= bus.D_WDATA;
            end else if (grant_i) begin
                // Fetches are always reads; MWDATA keeps its last value.
                bus.MREQ  <= 1'b1;
                bus.MRW   <= 1'b1;
                bus.MADDR <= bus.I_ADDR;
            end else if (done) begin
                bus.MREQ <= 1'b0;
                if (state == I_ACC) begin
                    bus.I_RVALID <= 1'b1;
                    bus.I_RDATA  <= rsp_data;
                end else begin
                    bus.D_RVALID <= 1'b1;
                    // A write completion leaves the load data untouched.
                    if (bus.MRW) begin
                        bus.D_RDATA <= rsp_data;
                    end
                end
            end
        end
    end

    // Starvation counter: consecutive D grants while a fetch is waiting
    always_ff @(posedge CLK) begin
        if (RST) begin
            dcnt <= 4'd0;
        end else if (state == IDLE) begin
            if (grant_i || !bus.I_REQ) begin
                dcnt <= 4'd0;
            end else if (grant_d && (dcnt < 4'(MAX_DBURST))) begin
                dcnt <= dcnt + 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_risc_toy_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_risc_toy_mem_arbiter
// Scoreboard bench: each test pushes the accesses it expects, in the order the
// arbiter should serve them; a monitor compares every memory launch and every
// completion pulse against the head of that queue. A small memory model
// answers MREQ after a programmable number of cycles.
// ---------------------------------------------------------------------------
module tb_risc_toy_mem_arbiter;

    localparam int AW = 30;
    localparam int DW = 32;

    logic CLK = 1'b0;
    logic RST;
    logic BUSY;
    logic ERR;

    risc_toy_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    risc_toy_mem_arbiter #(
        .AW(AW), .DW(DW), .MAX_DBURST(4), .TIMEOUT(8)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .bus  (bus),
        .BUSY (BUSY),
        .ERR  (ERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit            is_d;
        bit            rw;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] rdata;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          mon_e;
    int            n_chk = 0;
    int            n_err = 0;
    int            rv_seen = 0;
    bit            mon_en = 1'b1;
    bit            mem_silent = 1'b0;
    int            mack_delay = 0;
    logic          mreq_prev = 1'b0;
    logic [DW-1:0] last_d_rdata = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        if (a == 30'h10) return 32'h1234_5678;
        return 32'hA500_0000 ^ {2'b00, a} ^ {a[15:0], 16'h0};
    endfunction

    task automatic push_exp(input bit is_d, input bit rw, input logic [AW-1:0] a,
                            input logic [DW-1:0] wd);
        exp_t e;
        e.is_d  = is_d;
        e.rw    = rw;
        e.addr  = a;
        e.wdata = wd;
        e.rdata = rw ? mem_data(a) : '0;
        exp_q.push_back(e);
    endtask

    // Memory model: MACK after mack_delay extra MREQ cycles.
    initial begin
        int w;
        w = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (!mem_silent) begin
                if (bus.MREQ) begin
                    if (w >= mack_delay) begin
                        bus.MACK   = 1'b1;
                        bus.MRDATA = mem_data(bus.MADDR);
                        w = 0;
                    end else begin
                        bus.MACK = 1'b0;
                        w++;
                    end
                end else begin
                    bus.MACK = 1'b0;
                    w = 0;
                end
            end
        end
    end

    // Scoreboard monitor
    always @(negedge CLK) begin
        if (bus.I_RVALID || bus.D_RVALID) rv_seen++;
        if (mon_en) begin
            if (bus.MREQ && !mreq_prev) begin
                if (exp_q.size() == 0) begin
                    chk("launch_unexpected", 64'(bus.MADDR), 64'hFFFF_FFFF);
                end else begin
                    chk("launch_addr", 64'(bus.MADDR), 64'(exp_q[0].addr));
                    chk("launch_rw", 64'(bus.MRW), 64'(exp_q[0].rw));
                    if (!exp_q[0].rw) chk("launch_wdata", 64'(bus.MWDATA), 64'(exp_q[0].wdata));
                end
            end
            if (bus.I_RVALID || bus.D_RVALID) begin
                if (exp_q.size() == 0) begin
                    chk("rvalid_unexpected", {62'd0, bus.I_RVALID, bus.D_RVALID}, 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rvalid_side", {62'd0, bus.I_RVALID, bus.D_RVALID},
                        mon_e.is_d ? 64'd1 : 64'd2);
                    if (mon_e.is_d) begin
                        if (mon_e.rw) last_d_rdata = mon_e.rdata;
                        chk("d_rdata", 64'(bus.D_RDATA), 64'(last_d_rdata));
                    end else begin
                        chk("i_rdata", 64'(bus.I_RDATA), 64'(mon_e.rdata));
                    end
                end
            end
        end
        mreq_prev = bus.MREQ;
    end

    task automatic i_txn(input logic [AW-1:0] a);
        int t;
        t = 0;
        bus.I_REQ  = 1'b1;
        bus.I_ADDR = a;
        forever begin
            @(negedge CLK);
            if (bus.I_GNT) break;
            t++;
            if (t > 200) begin
                chk("i_gnt_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge CLK);
        #1;
        bus.I_REQ = 1'b0;
    endtask

    task automatic d_txn(input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] wd);
        int t;
        t = 0;
        bus.D_REQ   = 1'b1;
        bus.D_RW    = rw;
        bus.D_ADDR  = a;
        bus.D_WDATA = wd;
        forever begin
            @(negedge CLK);
            if (bus.D_GNT) break;
            t++;
            if (t > 200) begin
                chk("d_gnt_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge CLK);
        #1;
        bus.D_REQ = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge CLK);
            t++;
        end
        @(posedge CLK);
        #1;
        chk(tag, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic do_reset();
        RST = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        last_d_rdata = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rv0;
        int ic;
        int dc;
        int cnt;
        bit ig;
        bit dg;

        RST = 1'b1;
        bus.I_REQ = 1'b0; bus.I_ADDR = '0;
        bus.D_REQ = 1'b0; bus.D_RW = 1'b0; bus.D_ADDR = '0; bus.D_WDATA = '0;
        bus.MACK = 1'b0; bus.MRDATA = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // reset state
        chk("rst_mreq", 64'(bus.MREQ), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        chk("rst_err", 64'(ERR), 64'd0);
        chk("rst_maddr", 64'(bus.MADDR), 64'd0);
        chk("rst_i_rdata", 64'(bus.I_RDATA), 64'd0);
        chk("rst_d_rdata", 64'(bus.D_RDATA), 64'd0);
        chk("rst_rvalid", {62'd0, bus.I_RVALID, bus.D_RVALID}, 64'd0);

        // single fetch, cycle-exact
        mack_delay = 1;
        push_exp(1'b0, 1'b1, 30'h10, '0);
        bus.I_REQ = 1'b1; bus.I_ADDR = 30'h10;
        #1;
        chk("c0_i_gnt", 64'(bus.I_GNT), 64'd1);
        chk("c0_d_gnt", 64'(bus.D_GNT), 64'd0);
        @(posedge CLK); #1;
        bus.I_REQ = 1'b0;
        chk("c1_mreq", 64'(bus.MREQ), 64'd1);
        chk("c1_mrw", 64'(bus.MRW), 64'd1);
        chk("c1_maddr", 64'(bus.MADDR), 64'h10);
        chk("c1_busy", 64'(BUSY), 64'd1);
        @(posedge CLK); #1;
        chk("c2_busy", 64'(BUSY), 64'd1);
        chk("c2_i_rvalid", 64'(bus.I_RVALID), 64'd0);
        @(posedge CLK); #1;
        chk("c3_i_rvalid", 64'(bus.I_RVALID), 64'd1);
        chk("c3_i_rdata", 64'(bus.I_RDATA), 64'h1234_5678);
        chk("c3_mreq", 64'(bus.MREQ), 64'd0);
        chk("c3_busy", 64'(BUSY), 64'd0);
        @(posedge CLK); #1;
        chk("c4_i_rvalid", 64'(bus.I_RVALID), 64'd0);
        wait_drain("drain_fetch");

        // D read with a slow memory, then simultaneous D write and I fetch
        mack_delay = 2;
        push_exp(1'b1, 1'b1, 30'h30, '0);
        d_txn(1'b1, 30'h30, '0);
        wait_drain("drain_dread");
        mack_delay = 0;
        push_exp(1'b1, 1'b0, 30'h20, 32'hCAFE_0001);
        push_exp(1'b0, 1'b1, 30'h11, '0);
        fork
            i_txn(30'h11);
            d_txn(1'b0, 30'h20, 32'hCAFE_0001);
        join
        wait_drain("drain_dual");

        // D pending during a fetch but dropped before any grant: no access
        push_exp(1'b0, 1'b1, 30'h12, '0);
        mack_delay = 3;
        i_txn(30'h12);
        bus.D_REQ = 1'b1; bus.D_RW = 1'b1; bus.D_ADDR = 30'h3F;
        @(posedge CLK); #1;
        bus.D_REQ = 1'b0;
        wait_drain("drain_dropped");

        // starvation limit: both held, immediate MACK
        mack_delay = 0;
        for (int k = 0; k < 4; k++) push_exp(1'b1, 1'b1, 30'h100 + 30'(k), '0);
        push_exp(1'b0, 1'b1, 30'h200, '0);
        for (int k = 4; k < 8; k++) push_exp(1'b1, 1'b1, 30'h100 + 30'(k), '0);
        push_exp(1'b0, 1'b1, 30'h201, '0);
        ic = 0; dc = 0; cnt = 0;
        bus.I_REQ = 1'b1; bus.I_ADDR = 30'h200;
        bus.D_REQ = 1'b1; bus.D_RW = 1'b1; bus.D_ADDR = 30'h100;
        while (ic < 2 && cnt < 300) begin
            @(negedge CLK);
            ig = bus.I_GNT; dg = bus.D_GNT;
            @(posedge CLK); #1;
            cnt++;
            if (dg) begin dc++; bus.D_ADDR = 30'h100 + 30'(dc); end
            if (ig) begin ic++; bus.I_ADDR = 30'h200 + 30'(ic); end
        end
        bus.I_REQ = 1'b0; bus.D_REQ = 1'b0;
        chk("starve_dgrants", 64'(dc), 64'd8);
        chk("starve_igrants", 64'(ic), 64'd2);
        wait_drain("drain_starve");

        // reset in the middle of a D access, stray MACK afterwards
        mon_en = 1'b0; mem_silent = 1'b1; bus.MACK = 1'b0;
        rv0 = rv_seen;
        d_txn(1'b1, 30'h50, '0);
        chk("rstmid_mreq_before", 64'(bus.MREQ), 64'd1);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b1;
        @(posedge CLK); #1;
        chk("rstmid_mreq_after", 64'(bus.MREQ), 64'd0);
        chk("rstmid_busy_after", 64'(BUSY), 64'd0);
        RST = 1'b0;
        last_d_rdata = '0;
        repeat (2) @(posedge CLK);
        #1;
        bus.MACK = 1'b1; bus.MRDATA = 32'hFFFF_0000;
        @(posedge CLK); #1;
        bus.MACK = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk("rstmid_no_rvalid", 64'(rv_seen - rv0), 64'd0);
        chk("rstmid_idle", 64'(BUSY), 64'd0);
        chk("rstmid_d_rdata", 64'(bus.D_RDATA), 64'd0);

        // MACK while IDLE with no requests
        rv0 = rv_seen;
        bus.MACK = 1'b1; bus.MRDATA = 32'h0BAD_0BAD;
        @(posedge CLK); #1;
        bus.MACK = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("idle_mack_no_rvalid", 64'(rv_seen - rv0), 64'd0);
        chk("idle_mack_busy", 64'(BUSY), 64'd0);
        chk("idle_mack_mreq", 64'(bus.MREQ), 64'd0);

        // MACK never arrives
`ifdef ARB_TIMEOUT_EN
        mon_en = 1'b1;
        begin
            exp_t e;
            e.is_d = 1'b1; e.rw = 1'b1; e.addr = 30'h60; e.wdata = '0;
            e.rdata = 32'hDEAD_BEEF;
            exp_q.push_back(e);
        end
        d_txn(1'b1, 30'h60, '0);
        cnt = 0;
        while (bus.MREQ && cnt < 100) begin
            cnt++;
            @(posedge CLK); #1;
        end
        chk("timeout_mreq_cycles", 64'(cnt), 64'd8);
        chk("timeout_d_rvalid", 64'(bus.D_RVALID), 64'd1);
        chk("timeout_d_rdata", 64'(bus.D_RDATA), 64'hDEAD_BEEF);
        wait_drain("drain_timeout");
        repeat (5) @(posedge CLK);
        #1;
        chk("timeout_err_sticky", 64'(ERR), 64'd1);
        mon_en = 1'b0;
`else
        rv0 = rv_seen;
        d_txn(1'b1, 30'h60, '0);
        repeat (20) @(posedge CLK);
        #1;
        chk("nomack_mreq_held", 64'(bus.MREQ), 64'd1);
        chk("nomack_busy", 64'(BUSY), 64'd1);
        chk("nomack_no_rvalid", 64'(rv_seen - rv0), 64'd0);
        chk("nomack_err", 64'(ERR), 64'd0);
`endif
        do_reset();
        chk("final_err_cleared", 64'(ERR), 64'd0);
        chk("final_mreq", 64'(bus.MREQ), 64'd0);
        mem_silent = 1'b0;
        mon_en = 1'b1;

        // one more mixed round after reset
        mack_delay = 1;
        push_exp(1'b1, 1'b1, 30'h77, '0);
        push_exp(1'b0, 1'b1, 30'h78, '0);
        fork
            d_txn(1'b1, 30'h77, '0);
            i_txn(30'h78);
        join
        wait_drain("drain_final");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
